// File: rtl/union_lane_packer.sv
// Serial-to-nibble packer: assembles frame-aware 4-bit words from a bit stream
// and queues them in a small FIFO, presenting each head as a nibble plus two 2-bit lanes.
module union_lane_packer #(
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b0
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_bit,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_word,
  output logic [1:0]  out_lane0,
  output logic [1:0]  out_lane1,
  output logic [2:0]  out_nbits,
  output logic        out_last,
  output logic [15:0] word_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {COLLECT0, COLLECT1, COLLECT2, COLLECT3} state_t;

  typedef struct packed {
    logic [3:0] word;
    logic [2:0] nbits;
    logic       last;
  } entry_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, pos;
  logic [3:0]  shreg, shreg_nxt, filled;
  logic        accept, push, pop, full, empty;
  entry_t      push_e, head;
  entry_t      mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [1:0][1:0] lane_view;

  // Extra pointer bit separates full (MSBs differ) from empty (all equal).
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign cnt       = state;
  assign pos       = MSB_FIRST ? (2'd3 - cnt) : cnt;

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    push        = 1'b0;
    push_e      = '0;
    filled      = shreg;
    filled[pos] = in_bit;
    if (accept) begin
      if (in_last || state == COLLECT3) begin
        push         = 1'b1;
        push_e.word  = filled;
        push_e.nbits = {1'b0, cnt} + 3'd1;
        push_e.last  = in_last;
        state_nxt    = COLLECT0;
        shreg_nxt    = '0;
      end else begin
        shreg_nxt = filled;
        state_nxt = state_t'(cnt + 2'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT0;
      shreg      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      word_count <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && word_count != 16'hFFFF) word_count <= word_count + 16'd1;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= push_e;
  end

  assign head      = out_valid ? mem[rptr[AW-1:0]] : '0;
  assign out_word  = head.word;
  assign out_nbits = head.nbits;
  assign out_last  = head.last;
  assign lane_view = head.word;
  assign out_lane0 = lane_view[0];
  assign out_lane1 = lane_view[1];
endmodule

// File: doc/union_lane_packer.md
Name: union_lane_packer

Overview:
- Upstream feeder for the packed-union consumer stage. That stage writes a 4-bit nibble view and reads it back as two 2-bit lanes.
- Collects a serial bit stream (valid/ready) into 4-bit words, frame-aware, and buffers completed words in a small FIFO.
- Presents each word as the full nibble plus the two 2-bit lane views, with a downstream valid/ready handshake.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, >=2)
- MSB_FIRST, 0, 0: first accepted bit lands in word bit 0; 1: first accepted bit lands in word bit 3

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_bit/in_last valid
- in_ready  output  1  packer can accept a bit this cycle
- in_bit  input  1  serial data bit
- in_last  input  1  bit is last of frame; flushes partial word
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_word  output  4  head word, nibble view
- out_lane0  output  2  out_word[1:0] (lane index 0)
- out_lane1  output  2  out_word[3:2] (lane index 1)
- out_nbits  output  3  valid bits in head word, 1..4
- out_last  output  1  head word ends a frame
- word_count  output  16  completed words pushed since reset, saturating at 16'hFFFF

Behaviour:
- Reset (async assert, sync release): bit counter=0, shift register=0, FIFO empty, word_count=0. Outputs: in_ready=1, out_valid=0, out_word=0, out_lane0=0, out_lane1=0, out_nbits=0, out_last=0.
- in_ready = (FIFO occupancy < DEPTH).
  - Registered; no combinational path from out_ready or in_valid.
- Accept happens when in_valid && in_ready. in_bit is written at position cnt (MSB_FIRST=0) or 3-cnt (MSB_FIRST=1). cnt then increments.
- Assembly FSM:
  - COLLECT0: cnt=0, reset state.
  - COLLECT1..3: cnt=1..3.
  - An accept in COLLECT3 completes the word, pushes it with nbits=4 and last=in_last, and returns to COLLECT0.
  - An accept with in_last=1 in any state completes the word at nbits=cnt+1. Unfilled bit positions are 0. Pushes with last=1 and returns to COLLECT0.
  - A completing accept never stalls: in_ready guarantees a free FIFO slot.
- Latency: a completing bit accepted at edge N makes the word visible with out_valid=1 after edge N when the FIFO was empty. That is 1 cycle from accept to out_valid.
- Pop happens when out_valid && out_ready. Same-edge push and pop is legal: occupancy unchanged, order preserved.
- Outputs are driven from the FIFO head. When empty, out_word, out_lane0/1, out_nbits and out_last are 0.
- The lane views are pure slices of out_word. They are never independently stored.
- Full: in_ready=0; in_bit/in_last are ignored; the partial word is held unchanged.
- FIFO pointers wrap modulo DEPTH. Occupancy is tracked with one extra bit to distinguish full from empty.
- word_count increments on every push and saturates at all-ones. It does not wrap.
- Reset mid-frame discards the partial word and all FIFO contents. No partial word is emitted.
- in_valid=0 holds all state. The handshake has no timeout.

Test Plan:
- MSB_FIRST=0; bits 1,0,1,1 on consecutive cycles, out_ready=1 -> one cycle after 4th accept: out_valid=1, out_word=4'hD, out_lane0=2'b01, out_lane1=2'b11, out_nbits=4, out_last=0; word_count=1.
- MSB_FIRST=1; same bits -> out_word=4'hB, out_lane0=2'b11, out_lane1=2'b10.
- Bits 1,1 with in_last on 2nd (MSB_FIRST=0) -> out_word=4'h3, out_nbits=2, out_last=1. The following bit starts a fresh word at bit 0.
- out_ready=0; stream 12 bits, DEPTH=2 -> two words queued, in_ready drops to 0 after 8th accepted bit. Bits 9-12 are held off until out_ready=1. Then words pop in order, and in_ready returns 1 the cycle after the first pop.
- FIFO holds 1 word; out_ready=1 on the same edge as a completing accept -> occupancy stays 1, new word becomes head next cycle, no loss or duplication.
- Assert rst_n=0 asynchronously after 3 bits with 1 word queued -> out_valid=0 and in_ready=1 immediately. After release, 4 fresh bits produce exactly one word with word_count=1.
